// File: rtl/bias_relu_pkg.sv
// Shared constants and the round/ReLU/saturate helper for bias stages.
package bias_relu_pkg;

    localparam int BIAS_W  = 18;
    localparam int OUT_W   = 16;
    localparam int OUT_MAX = 32767;
    localparam int OUT_MIN = -32768;

    // Round half up, arithmetic right shift by 'shift' (>=1), then clamp to
    // the 16-bit activation range. With relu set, negatives clamp to zero.
    function automatic logic signed [OUT_W-1:0] round_shift_sat(
        input logic signed [31:0] sum,
        input logic               relu,
        input int                 shift = 2
    );
        logic signed [31:0] r;
        r = (sum + (32'sd1 <<< (shift - 1))) >>> shift;
        if (relu && (r < 0)) begin
            return '0;
        end
        if (r > OUT_MAX) begin
            return OUT_W'(OUT_MAX);
        end
        if (r < OUT_MIN) begin
            return OUT_W'(OUT_MIN);
        end
        return r[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/bias_relu_stage_if.sv
// Handshake and data bus between adder trees, bias ROM and the bias/ReLU stage.
interface bias_relu_stage_if #(
    parameter int N_LANES    = 8,
    parameter int NUM_GROUPS = 2,
    parameter int ACC_W      = 18
);
    localparam int GRP_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    logic [NUM_GROUPS*N_LANES*18-1:0] bias_bank;
    logic                             frame_start;
    logic                             in_valid;
    logic                             in_ready;
    logic [N_LANES*ACC_W-1:0]         in_acc;
    logic                             out_valid;
    logic                             out_ready;
    logic [N_LANES*16-1:0]            out_data;
    logic [GRP_W-1:0]                 out_grp;
    logic                             out_last;

    modport master (
        output bias_bank, frame_start, in_valid, in_acc, out_ready,
        input  in_ready, out_valid, out_data, out_grp, out_last
    );

    modport slave (
        input  bias_bank, frame_start, in_valid, in_acc, out_ready,
        output in_ready, out_valid, out_data, out_grp, out_last
    );

endinterface

// File: rtl/bias_relu_lane.sv
// Output stage for one lane: round-shift, optional ReLU, saturate, register.
module bias_relu_lane
    import bias_relu_pkg::*;
#(
    parameter int SUM_W = 20,
    parameter int SHIFT = 2,
    parameter int RELU  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic signed [SUM_W-1:0] sum,
    output logic [OUT_W-1:0]        data_q
);

    logic [OUT_W-1:0] data_d;

    // Load a new activation only when the pipeline advances with valid data.
    always_comb begin
        data_d = data_q;
        if (en && in_valid) begin
            data_d = round_shift_sat(32'(sum), (RELU != 0), SHIFT);
        end
    end

    // Activation register, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/bias_relu_stage.sv
// Two-stage bias-add / ReLU / saturate pipeline with per-beat bias group select.
module bias_relu_stage
    import bias_relu_pkg::*;
#(
    parameter int N_adder_tree = 8,
    parameter int NUM_GROUPS   = 2,
    parameter int ACC_W        = 18,
    parameter int SHIFT        = 2,
    parameter int RELU         = 1
) (
    input logic              clk,
    input logic              rst,
    bias_relu_stage_if.slave bus
);

    localparam int GRP_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int SUM_W = ACC_W + 2;
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NUM_GROUPS - 1);

    logic en;
    logic accept;
    logic [GRP_W-1:0] grp_sel;

    logic [GRP_W-1:0] grp_cnt_d, grp_cnt_q;
    logic             s1_valid_d, s1_valid_q;
    logic [GRP_W-1:0] s1_grp_d, s1_grp_q;
    logic signed [SUM_W-1:0] s1_sum_d [N_adder_tree];
    logic signed [SUM_W-1:0] s1_sum_q [N_adder_tree];
    logic             out_valid_d, out_valid_q;
    logic [GRP_W-1:0] out_grp_d, out_grp_q;
    logic             out_last_d, out_last_q;
    logic [OUT_W-1:0] lane_data [N_adder_tree];

    assign en          = !out_valid_q || bus.out_ready;
    assign accept      = bus.in_valid && en;
    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_grp   = out_grp_q;
    assign bus.out_last  = out_last_q;

    // frame_start forces the current beat onto group 0.
    always_comb begin
        grp_sel = bus.frame_start ? '0 : grp_cnt_q;
    end

    // Next state for group counter, stage 1 and stage-2 control.
    always_comb begin
        grp_cnt_d   = grp_cnt_q;
        s1_valid_d  = s1_valid_q;
        s1_grp_d    = s1_grp_q;
        out_valid_d = out_valid_q;
        out_grp_d   = out_grp_q;
        out_last_d  = out_last_q;
        for (int i = 0; i < N_adder_tree; i++) begin
            s1_sum_d[i] = s1_sum_q[i];
        end
        if (en) begin
            s1_valid_d = accept;
            s1_grp_d   = grp_sel;
            if (accept) begin
                grp_cnt_d = (grp_sel == GRP_LAST) ? '0 : grp_sel + GRP_W'(1);
                for (int i = 0; i < N_adder_tree; i++) begin
                    s1_sum_d[i] =
                        SUM_W'($signed(bus.in_acc[ACC_W*i +: ACC_W])) +
                        SUM_W'($signed(bus.bias_bank[BIAS_W*(int'(grp_sel)*N_adder_tree + i) +: BIAS_W]));
                end
            end else if (bus.frame_start) begin
                grp_cnt_d = '0;
            end
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_grp_d  = s1_grp_q;
                out_last_d = (s1_grp_q == GRP_LAST);
            end
        end
    end

    // Pipeline registers; reset flushes both stages and the group counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_cnt_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_grp_q    <= '0;
            out_valid_q <= 1'b0;
            out_grp_q   <= '0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < N_adder_tree; i++) begin
                s1_sum_q[i] <= '0;
            end
        end else begin
            grp_cnt_q   <= grp_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_grp_q    <= s1_grp_d;
            out_valid_q <= out_valid_d;
            out_grp_q   <= out_grp_d;
            out_last_q  <= out_last_d;
            for (int i = 0; i < N_adder_tree; i++) begin
                s1_sum_q[i] <= s1_sum_d[i];
            end
        end
    end

    for (genvar g = 0; g < N_adder_tree; g++) begin : g_lane
        bias_relu_lane #(
            .SUM_W (SUM_W),
            .SHIFT (SHIFT),
            .RELU  (RELU)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .in_valid (s1_valid_q),
            .sum      (s1_sum_q[g]),
            .data_q   (lane_data[g])
        );
        assign bus.out_data[OUT_W*g +: OUT_W] = lane_data[g];
    end

endmodule

// File: tb/tb_bias_relu_stage.sv
// Scoreboard bench: one ReLU and one signed-saturate instance share stimulus.
module tb_bias_relu_stage;

    localparam int N  = 8;
    localparam int G  = 2;
    localparam int AW = 18;
    localparam int BW = 18;
    localparam int SH = 2;
    localparam int GW = 1;

    typedef struct packed {
        logic [N*16-1:0] relu_d;
        logic [N*16-1:0] sat_d;
        logic [GW-1:0]   grp;
        logic            last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bias_relu_stage_if #(.N_LANES(N), .NUM_GROUPS(G), .ACC_W(AW)) ifa ();
    bias_relu_stage_if #(.N_LANES(N), .NUM_GROUPS(G), .ACC_W(AW)) ifb ();

    assign ifb.bias_bank   = ifa.bias_bank;
    assign ifb.frame_start = ifa.frame_start;
    assign ifb.in_valid    = ifa.in_valid;
    assign ifb.in_acc      = ifa.in_acc;
    assign ifb.out_ready   = ifa.out_ready;

    bias_relu_stage #(.N_adder_tree(N), .NUM_GROUPS(G), .ACC_W(AW), .SHIFT(SH), .RELU(1))
        u_relu (.clk(clk), .rst(rst), .bus(ifa));
    bias_relu_stage #(.N_adder_tree(N), .NUM_GROUPS(G), .ACC_W(AW), .SHIFT(SH), .RELU(0))
        u_sat (.clk(clk), .rst(rst), .bus(ifb));

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_grp = 0;
    bit   stream_done;

    function automatic int ref_lane(int s, bit relu);
        real x;
        int  r;
        x = $floor((real'(s) + 2.0 ** (SH - 1)) / (2.0 ** SH));
        r = int'(x);
        if (relu && r < 0) r = 0;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    function automatic exp_t model(logic [N*AW-1:0] acc, logic [G*N*BW-1:0] bank, int g);
        exp_t e;
        int   s;
        for (int i = 0; i < N; i++) begin
            s = int'($signed(acc[AW*i +: AW])) + int'($signed(bank[BW*(g*N+i) +: BW]));
            e.relu_d[16*i +: 16] = 16'(ref_lane(s, 1'b1));
            e.sat_d[16*i +: 16]  = 16'(ref_lane(s, 1'b0));
        end
        e.grp  = GW'(g);
        e.last = (g == G - 1);
        return e;
    endfunction

    task automatic chk(input string name, input logic [N*16-1:0] act, input logic [N*16-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic set_bias(input int g, input int lane, input int val);
        ifa.bias_bank[BW*(g*N+lane) +: BW] = BW'(val);
    endtask

    task automatic rand_bank();
        for (int i = 0; i < G*N; i++) ifa.bias_bank[BW*i +: BW] = BW'($urandom);
    endtask

    function automatic logic [N*AW-1:0] rand_acc();
        logic [N*AW-1:0] a;
        for (int i = 0; i < N; i++) a[AW*i +: AW] = AW'($urandom);
        return a;
    endfunction

    task automatic drive_beat(input logic [N*AW-1:0] acc, input bit fs);
        int n;
        ifa.in_valid    = 1'b1;
        ifa.in_acc      = acc;
        ifa.frame_start = fs;
        n = 0;
        forever begin
            @(negedge clk);
            if (ifa.in_ready) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stuck at %b expected 1", ifa.in_ready);
                break;
            end
        end
        @(posedge clk);
        #1;
        ifa.in_valid    = 1'b0;
        ifa.frame_start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Reference model: predict the response of every accepted beat.
    always @(negedge clk) begin : imon
        int sel;
        if (!rst) begin
            sel = ifa.frame_start ? 0 : model_grp;
            if (ifa.in_valid && ifa.in_ready) begin
                q.push_back(model(ifa.in_acc, ifa.bias_bank, sel));
                model_grp = (sel == G - 1) ? 0 : sel + 1;
            end else if (ifa.frame_start && ifa.in_ready) begin
                model_grp = 0;
            end
        end
    end

    // Output monitor: compare each presented beat against the queue head.
    always @(negedge clk) begin : omon
        exp_t e;
        if (!rst) begin
            chk("valid_match", 128'(ifb.out_valid), 128'(ifa.out_valid));
            if (ifa.out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: out_valid=1 data %h expected no beat", ifa.out_data);
                end else begin
                    e = q[0];
                    chk("data_relu", ifa.out_data, e.relu_d);
                    chk("data_sat", ifb.out_data, e.sat_d);
                    chk("out_grp", 128'(ifa.out_grp), 128'(e.grp));
                    chk("out_last", 128'(ifa.out_last), 128'(e.last));
                    if (ifa.out_ready) begin
                        void'(q.pop_front());
                    end else begin
                        chk("stall_in_ready", 128'(ifa.in_ready), 128'(0));
                    end
                end
            end
        end
    end

    initial begin
        logic [N*AW-1:0] acc;
        ifa.in_valid    = 1'b0;
        ifa.frame_start = 1'b0;
        ifa.in_acc      = '0;
        ifa.out_ready   = 1'b1;
        rand_bank();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 128'(ifa.out_valid), 128'(0));
        chk("rst_out_data", ifa.out_data, '0);
        chk("rst_out_data_sat", ifb.out_data, '0);
        chk("rst_out_grp", 128'(ifa.out_grp), 128'(0));
        chk("rst_out_last", 128'(ifa.out_last), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 128'(ifa.in_ready), 128'(1));
        @(posedge clk);
        #1;

        // Basic add with explicit latency check on lane 0
        set_bias(0, 0, 5868);
        acc = rand_acc();
        acc[AW-1:0] = AW'(256);
        drive_beat(acc, 1'b1);
        @(negedge clk);
        chk("latency_not_early", 128'(ifa.out_valid), 128'(0));
        @(negedge clk);
        chk("latency_valid", 128'(ifa.out_valid), 128'(1));
        chk("basic_lane0", 128'(ifa.out_data[15:0]), 128'(16'd1531));
        drain();

        // ReLU clamp versus signed output
        set_bias(0, 0, -5888);
        acc = rand_acc();
        acc[AW-1:0] = '0;
        drive_beat(acc, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("relu_lane0", 128'(ifa.out_data[15:0]), 128'(16'h0000));
        chk("signed_lane0", 128'(ifb.out_data[15:0]), 128'(16'hFA40));
        drain();

        // Positive saturation
        set_bias(0, 0, 23964);
        acc = rand_acc();
        acc[AW-1:0] = AW'(131071);
        drive_beat(acc, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("sat_lane0", 128'(ifa.out_data[15:0]), 128'(16'h7FFF));
        drain();

        // Group cycling, five back-to-back beats
        rand_bank();
        for (int i = 0; i < 5; i++) drive_beat(rand_acc(), i == 0);
        drain();

        // frame_start on beat 2 restarts grouping
        for (int i = 0; i < 5; i++) drive_beat(rand_acc(), i == 0 || i == 2);
        drain();

        // Backpressure: three-cycle stall mid-stream
        fork
            for (int i = 0; i < 10; i++) drive_beat(rand_acc(), 1'b0);
            begin
                repeat (4) @(posedge clk);
                #1;
                ifa.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                ifa.out_ready = 1'b1;
            end
        join
        drain();

        // Random traffic with random backpressure and frame starts
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) rand_bank();
                    drive_beat(rand_acc(), $urandom_range(0, 7) == 0);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1;
                    ifa.out_ready = ($urandom_range(0, 3) != 0);
                end
                ifa.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight
        drive_beat(rand_acc(), 1'b0);
        drive_beat(rand_acc(), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_flush_valid", 128'(ifa.out_valid), 128'(0));
        chk("rst_flush_valid_sat", 128'(ifb.out_valid), 128'(0));
        q.delete();
        model_grp = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive_beat(rand_acc(), 1'b0);
        drain();
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bias_relu_stage.md
Name: bias_relu_stage

Overview:
- Consumer side of the bias ROM blocks: reads a constant bias bank (NUM_GROUPS groups × N_adder_tree lanes × 18 bits) and applies it to adder-tree accumulator beats.
- Per lane: add bias, optional ReLU, round-shift, then saturate to a 16-bit activation.
- Two-stage valid/ready pipeline with a group counter selecting the bias slice per beat.
- Sits between the per-layer adder trees and the activation buffer writer.

Parameters:
- N_adder_tree, 8, lanes per beat; equals lanes per bias group.
- NUM_GROUPS, 2, bias groups cycled per frame (e.g. layer5 part 1 and part 2).
- ACC_W, 18, accumulator width, two's complement, same Q-format as bias.
- SHIFT, 2, right shift (≥1) from accumulator Q-format to output Q-format.
- RELU, 1, 1 = clamp negatives to 0; 0 = signed saturate.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, asynchronous active-high reset.
- bias_bank, input, NUM_GROUPS*N_adder_tree*18, concatenated bias ROM outputs; group g, lane i at bits [18*(g*N_adder_tree+i) +: 18].
- frame_start, input, 1, sync pulse; group counter returns to 0.
- in_valid, input, 1, accumulator beat valid.
- in_ready, output, 1, stage can accept.
- in_acc, input, N_adder_tree*ACC_W, lane i at [ACC_W*i +: ACC_W].
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts.
- out_data, output, N_adder_tree*16, lane i at [16*i +: 16].
- out_grp, output, clog2(NUM_GROUPS) (min 1), group index used for this beat.
- out_last, output, 1, beat used group NUM_GROUPS-1.

Behaviour:
- Reset (async, rst=1): all valid flags, grp_cnt, out_data, out_grp, out_last = 0. in_ready = 1 once rst deasserts.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en (combinational). Both stages advance only when en=1. Bubbles propagate as valid=0.
- Input acceptance: accept = in_valid && in_ready.
- Stage 1 on en:
  - s1_valid <= accept.
  - On accept, per lane: s1_sum <= sext(in_acc, ACC_W+2) + sext(bias[grp_sel][i], ACC_W+2).
  - s1_grp <= grp_sel.
- Group select: grp_sel = frame_start ? 0 : grp_cnt.
- Group counter on accept: grp_cnt <= (grp_sel == NUM_GROUPS-1) ? 0 : grp_sel+1.
- Group counter when frame_start without accept: grp_cnt <= 0.
- Stage 2 on en: out_valid <= s1_valid. On s1_valid, per lane:
  - r = (s1_sum + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift, round half up).
  - RELU=1: r<0 → 0; r>32767 → 32767; else r.
  - RELU=0: clamp to [-32768, 32767].
  - out_grp <= s1_grp; out_last <= (s1_grp == NUM_GROUPS-1).
- Latency: accepted beat appears on out_valid 2 cycles later absent stall. Throughput 1 beat/cycle.
- Stall: out_valid && !out_ready holds all stage registers and grp_cnt; in_ready=0. No data loss or duplication.
- in_acc, bias_bank and frame_start are sampled only on accept (frame_start also when idle). Outputs are stable while stalled.
- Reset mid-operation flushes both stages; in-flight beats are dropped; grp_cnt returns to 0.

Decomposition:
- Package bias_relu_pkg:
  - constants BIAS_W=18, OUT_W=16, OUT_MAX=32767, OUT_MIN=-32768;
  - function round_shift_sat(sum, relu) shared with future layer stages.
- One natural sub-module: bias_relu_lane (stage-2 round/ReLU/saturate for one lane), instantiated N_adder_tree times by generate loop. The counter and handshake stay in the top.

Test Plan:
- Basic add: lane0 acc=256, group0 lane0 bias=18'b000001011011101100 (5868). One beat, out_ready=1 → out_data lane0=1531 two cycles later; out_grp=0.
- ReLU clamp: acc=0, bias=18'b111110100100000000 (-5888), RELU=1 → lane=0. Same with RELU=0 → lane=-1472 (16'hFA40).
- Saturation: acc=131071, bias=18'b000101110110011100 (23964) → lane=32767 (16'h7FFF).
- Group cycling: 5 back-to-back beats, NUM_GROUPS=2 → out_grp 0,1,0,1,0; out_last 0,1,0,1,0.
- frame_start coincident with beat 2 → beats 2,3 use groups 0,1.
- Backpressure: out_ready low for 3 cycles mid-stream with in_valid held → in_ready=0 during stall; out_data stable; every beat delivered exactly once, in order.
- Reset mid-stream: assert rst with 2 beats in flight → out_valid=0 immediately (async); after release, next beat uses group 0 and nothing stale is emitted.
